// File: rtl/otl_spi_slave.sv
// SPI register-access slave. Receives 24-bit frames (R/W flag, address,
// data) on an asynchronous SPI link, issues one-cycle write strobes or read
// requests on the register side, and returns read data on spi_miso.
module otl_spi_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int RD_TIMEOUT  = 2
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       spi_le,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] m_wraddr,
    output logic [7:0] m_wrdata,
    output logic       m_wrvalid,
    output logic [7:0] m_rdaddr,
    output logic       m_rdreq,
    input  logic [7:0] m_rddata,
    input  logic       m_rdvalid,
    output logic       frame_err
);

    localparam int RDW = $clog2(RD_TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, OVER} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] le_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   clk_q;
    logic                   le_q;
    logic [SYNC_STAGES:0]   flush;
    logic                   armed;

    logic clk_s, le_s, mosi_s;
    logic clk_rise, clk_fall, le_fall, le_rise;

    state_t          state;
    logic [4:0]      cnt;
    logic [23:0]     sr;
    logic [7:0]      out_sr;
    logic            is_rd;
    logic            rd_pend;
    logic            rd_late;
    logic [RDW-1:0]  rd_left;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign le_s   = le_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign clk_rise = clk_s & ~clk_q;
    assign clk_fall = ~clk_s & clk_q;
    // A frame may only start once le has been seen high after reset, so a
    // frame interrupted by reset is not resumed half-way through.
    assign le_fall  = armed & le_q & ~le_s;
    assign le_rise  = le_s & ~le_q;

    // Synchronize the SPI inputs into sys_clk and track post-reset arming.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            clk_sync  <= '0;
            le_sync   <= '1;
            mosi_sync <= '0;
            clk_q     <= 1'b0;
            le_q      <= 1'b1;
            flush     <= '0;
            armed     <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            le_sync   <= {le_sync[SYNC_STAGES-2:0], spi_le};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            clk_q     <= clk_s;
            le_q      <= le_s;
            flush     <= {flush[SYNC_STAGES-1:0], 1'b1};
            if (flush[SYNC_STAGES] && le_s)
                armed <= 1'b1;
        end
    end

    // Frame FSM, read-response window and register-side strobes.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            out_sr    <= '0;
            is_rd     <= 1'b0;
            rd_pend   <= 1'b0;
            rd_late   <= 1'b0;
            rd_left   <= '0;
            spi_miso  <= 1'b0;
            m_wraddr  <= '0;
            m_wrdata  <= '0;
            m_wrvalid <= 1'b0;
            m_rdaddr  <= '0;
            m_rdreq   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            m_wrvalid <= 1'b0;
            m_rdreq   <= 1'b0;
            frame_err <= 1'b0;

            // Only the first m_rdvalid inside the window is taken; once the
            // window closes without one, the frame is marked late.
            if (rd_pend) begin
                if (m_rdvalid) begin
                    out_sr  <= m_rddata;
                    rd_pend <= 1'b0;
                end else if (rd_left == RDW'(1)) begin
                    rd_pend <= 1'b0;
                    rd_late <= 1'b1;
                end else begin
                    rd_left <= rd_left - RDW'(1);
                end
            end

            case (state)
                IDLE: begin
                    spi_miso <= 1'b0;
                    if (le_fall) begin
                        state   <= SHIFT;
                        cnt     <= '0;
                        sr      <= '0;
                        out_sr  <= '0;
                        is_rd   <= 1'b0;
                        rd_late <= 1'b0;
                        rd_pend <= 1'b0;
                    end
                end
                default: begin
                    if (le_rise) begin
                        state    <= IDLE;
                        spi_miso <= 1'b0;
                        rd_pend  <= 1'b0;
                        if (state == DONE && sr[23]) begin
                            m_wrvalid <= 1'b1;
                            m_wraddr  <= sr[15:8];
                            m_wrdata  <= sr[7:0];
                        end else if (state != DONE || rd_late || rd_pend) begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        if (clk_rise && !le_s) begin
                            sr <= {sr[22:0], mosi_s};
                            if (cnt != 5'd25)
                                cnt <= cnt + 5'd1;
                            if (cnt == 5'd23)
                                state <= DONE;
                            if (cnt == 5'd24)
                                state <= OVER;
                            // sr[14] becomes frame bit 23 once this 16th bit lands.
                            if (cnt == 5'd15 && !sr[14]) begin
                                m_rdreq  <= 1'b1;
                                m_rdaddr <= {sr[6:0], mosi_s};
                                is_rd    <= 1'b1;
                                rd_pend  <= 1'b1;
                                rd_left  <= RDW'(RD_TIMEOUT + 1);
                            end
                        end
                        if (clk_fall) begin
                            if (state == SHIFT && is_rd && cnt >= 5'd16)
                                spi_miso <= out_sr[3'(5'd23 - cnt)];
                            else
                                spi_miso <= 1'b0;
                        end
                        if (state != SHIFT)
                            spi_miso <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otl_spi_slave.sv
// Directed plus randomized frame test for otl_spi_slave with a frame-level
// reference model and a register-side read responder.
module tb_otl_spi_slave;

    localparam int RD_TIMEOUT = 2;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       spi_clk;
    logic       spi_le;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] m_wraddr;
    logic [7:0] m_wrdata;
    logic       m_wrvalid;
    logic [7:0] m_rdaddr;
    logic       m_rdreq;
    logic [7:0] m_rddata;
    logic       m_rdvalid;
    logic       frame_err;

    otl_spi_slave #(.SYNC_STAGES(2), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .spi_clk   (spi_clk),
        .spi_le    (spi_le),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .m_wraddr  (m_wraddr),
        .m_wrdata  (m_wrdata),
        .m_wrvalid (m_wrvalid),
        .m_rdaddr  (m_rdaddr),
        .m_rdreq   (m_rdreq),
        .m_rddata  (m_rddata),
        .m_rdvalid (m_rdvalid),
        .frame_err (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // Event counters sampled away from the active edge.
    int         wr_n = 0, rd_n = 0, err_n = 0, both_n = 0;
    logic [7:0] wa = 8'h00, wd = 8'h00, ra = 8'h00;

    always @(negedge sys_clk) begin
        if (m_wrvalid) begin
            wr_n <= wr_n + 1;
            wa   <= m_wraddr;
            wd   <= m_wrdata;
        end
        if (m_rdreq) begin
            rd_n <= rd_n + 1;
            ra   <= m_rdaddr;
        end
        if (frame_err)
            err_n <= err_n + 1;
        if (m_wrvalid && m_rdreq)
            both_n <= both_n + 1;
    end

    // Register-side responder: answers a read request after resp_delay cycles.
    logic       resp_en    = 1'b0;
    int         resp_delay = 1;
    logic [7:0] resp_data  = 8'h00;

    initial begin
        m_rdvalid = 1'b0;
        m_rddata  = 8'h00;
        forever begin
            @(negedge sys_clk);
            if (m_rdreq && resp_en) begin
                repeat (resp_delay) @(negedge sys_clk);
                m_rddata  = resp_data;
                m_rdvalid = 1'b1;
                @(negedge sys_clk);
                m_rdvalid = 1'b0;
                m_rddata  = 8'h00;
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    logic [7:0] rx_byte;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Clock out bits [first, first+count) of a frame; bits past 23 send 0.
    // Master samples miso just before each rising edge; rises 17..24 give bits 7..0.
    task automatic spi_bits(input logic [23:0] word, input int first, input int count, input int half);
        for (int i = first; i < first + count; i++) begin
            spi_mosi = (i < 24) ? word[23 - i] : 1'b0;
            wait_cyc(half);
            if (i >= 16 && i < 24)
                rx_byte[23 - i] = spi_miso;
            spi_clk = 1'b1;
            wait_cyc(half);
            spi_clk = 1'b0;
        end
    endtask

    task automatic run_frame(input string tag, input logic [23:0] word, input int nclk, input int half,
                             input logic en, input int delay, input logic [7:0] data);
        int   wr0, rd0, err0;
        logic exp_wr, exp_rd, good, exp_err;
        logic [7:0] exp_rx;
        wr0 = wr_n; rd0 = rd_n; err0 = err_n;
        resp_en = en; resp_delay = delay; resp_data = data;
        rx_byte = 8'h00;
        spi_le  = 1'b0;
        wait_cyc(half);
        spi_bits(word, 0, nclk, half);
        wait_cyc(half);
        spi_le = 1'b1;
        wait_cyc(14);
        resp_en = 1'b0;

        exp_wr  = word[23] && (nclk == 24);
        exp_rd  = !word[23] && (nclk >= 16);
        good    = en && (delay <= RD_TIMEOUT);
        exp_err = !((nclk == 24) && (word[23] || good));
        exp_rx  = (word[23] || !good) ? 8'h00 : data;

        check({tag, " wrvalid count"}, 32'(wr_n - wr0), exp_wr ? 32'd1 : 32'd0);
        check({tag, " rdreq count"},   32'(rd_n - rd0), exp_rd ? 32'd1 : 32'd0);
        check({tag, " frame_err count"}, 32'(err_n - err0), exp_err ? 32'd1 : 32'd0);
        if (exp_wr) begin
            check({tag, " wraddr"}, 32'(wa), 32'(word[15:8]));
            check({tag, " wrdata"}, 32'(wd), 32'(word[7:0]));
        end
        if (exp_rd)
            check({tag, " rdaddr"}, 32'(ra), 32'(word[15:8]));
        if (nclk == 24)
            check({tag, " miso byte"}, 32'(rx_byte), 32'(exp_rx));
        check({tag, " wr/rd overlap"}, 32'(both_n), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " miso"},      32'(spi_miso),  32'd0);
        check({tag, " wrvalid"},   32'(m_wrvalid), 32'd0);
        check({tag, " rdreq"},     32'(m_rdreq),   32'd0);
        check({tag, " frame_err"}, 32'(frame_err), 32'd0);
        check({tag, " wraddr"},    32'(m_wraddr),  32'd0);
        check({tag, " wrdata"},    32'(m_wrdata),  32'd0);
        check({tag, " rdaddr"},    32'(m_rdaddr),  32'd0);
    endtask

    initial begin
        int wr0, rd0, err0;
        logic [23:0] w;
        int n, h, r;
        reset    = 1'b1;
        spi_clk  = 1'b0;
        spi_le   = 1'b1;
        spi_mosi = 1'b0;
        rx_byte  = 8'h00;
        wait_cyc(5);
        check_reset_outputs("reset");
        reset = 1'b0;
        wait_cyc(10);

        run_frame("write 803AC5", 24'h803AC5, 24, 8, 1'b0, 1, 8'h00);
        run_frame("read 12 A5",   24'h001200, 24, 8, 1'b1, 1, 8'hA5);
        run_frame("read no resp", 24'h004400, 24, 8, 1'b0, 1, 8'h00);
        run_frame("read delay 2", 24'h00C300, 24, 8, 1'b1, 2, 8'h3C);
        run_frame("read delay 3", 24'h005A00, 24, 8, 1'b1, 3, 8'hFF);
        run_frame("write short",  24'h8055AA, 20, 8, 1'b0, 1, 8'h00);
        run_frame("write long",   24'h8055AA, 25, 8, 1'b0, 1, 8'h00);
        run_frame("write 800102", 24'h800102, 24, 8, 1'b0, 1, 8'h00);
        run_frame("read short",   24'h00EE00, 20, 8, 1'b1, 1, 8'h81);
        run_frame("read 7E",      24'h007E00, 24, 8, 1'b1, 1, 8'h96);

        // Reset at bit 12 of a write frame, le held low through and after reset.
        wr0 = wr_n; rd0 = rd_n; err0 = err_n;
        spi_le = 1'b0;
        wait_cyc(8);
        spi_bits(24'h807733, 0, 12, 8);
        reset = 1'b1;
        wait_cyc(3);
        check_reset_outputs("midframe reset");
        reset = 1'b0;
        wait_cyc(4);
        spi_bits(24'h807733, 12, 12, 8);
        wait_cyc(8);
        spi_le = 1'b1;
        wait_cyc(14);
        check("midframe wrvalid count", 32'(wr_n - wr0), 32'd0);
        check("midframe rdreq count",   32'(rd_n - rd0), 32'd0);
        check("midframe frame_err count", 32'(err_n - err0), 32'd0);
        run_frame("after reset", 24'h809CE7, 24, 8, 1'b0, 1, 8'h00);

        for (int k = 0; k < 20; k++) begin
            w = 24'($urandom());
            r = int'($urandom_range(0, 9));
            n = (r == 0) ? 20 : (r == 1) ? 25 : (r == 2) ? 10 : 24;
            h = int'($urandom_range(8, 11));
            run_frame($sformatf("rand%0d", k), w, n, h, ($urandom_range(0, 3) != 0),
                      int'($urandom_range(1, 3)), 8'($urandom()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
